// File: rtl/keccak_pkg.sv
// Shared Keccak state types: one lane/state layout for both the loader and the
// state-to-bitstring direction.
package keccak_pkg;
    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;

    typedef logic [LANE_W-1:0] lane_t;
    // Indexed [x][y][z]
    typedef logic [4:0][4:0][LANE_W-1:0] state_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } load_state_e;
endpackage

// File: rtl/string_to_state_loader_if.sv
// Lane-in / state-out handshake bundle of the bitstring-to-state loader.
interface string_to_state_loader_if;
    import keccak_pkg::*;

    logic        in_valid;
    logic        in_ready;
    lane_t       in_lane;
    logic        in_last;
    logic        state_valid;
    logic        state_ready;
    state_t      state_o;
    logic [4:0]  lanes_o;

    modport master (
        output in_valid, in_lane, in_last, state_ready,
        input  in_ready, state_valid, state_o, lanes_o
    );

    modport slave (
        input  in_valid, in_lane, in_last, state_ready,
        output in_ready, state_valid, state_o, lanes_o
    );
endinterface

// File: rtl/keccak_xy_counter.sv
// Lane position counter walking the 5x5 (x,y) plane in x-fastest order,
// plus a running lane count; no division on the lane index.
module keccak_xy_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_advance,
    input  logic       i_clear,
    output logic [2:0] o_x,
    output logic [2:0] o_y,
    output logic [4:0] o_count
);
    logic [2:0] r_x;
    logic [2:0] r_y;
    logic [4:0] r_count;

    // Clear wins over advance so a block release never carries a stale position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x     <= 3'd0;
            r_y     <= 3'd0;
            r_count <= 5'd0;
        end else if (i_clear) begin
            r_x     <= 3'd0;
            r_y     <= 3'd0;
            r_count <= 5'd0;
        end else if (i_advance) begin
            if (r_x == 3'd4) begin
                r_x <= 3'd0;
                r_y <= (r_y == 3'd4) ? 3'd0 : r_y + 3'd1;
            end else begin
                r_x <= r_x + 3'd1;
            end
            r_count <= r_count + 5'd1;
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_count = r_count;
endmodule

// File: rtl/string_to_state_loader.sv
// Assembles serially delivered 64-bit lanes into the 5x5x64 Keccak state and
// holds the finished block until the permutation core takes it.
module string_to_state_loader
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    string_to_state_loader_if.slave   bus
);
    localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

    load_state_e r_state;
    load_state_e w_state_next;
    state_t      r_state_arr;
    logic [2:0]  w_x;
    logic [2:0]  w_y;
    logic [4:0]  w_count;
    logic        w_accept;
    logic        w_close;
    logic        w_release;

    assign w_accept  = bus.in_valid && (r_state == ST_FILL);
    assign w_close   = w_accept && (bus.in_last || (w_count == LAST_IDX));
    assign w_release = (r_state == ST_FULL) && bus.state_ready;

    keccak_xy_counter u_xy (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_accept),
        .i_clear   (w_release),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_count   (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: if (w_close)          w_state_next = ST_FULL;
            ST_FULL: if (bus.state_ready)  w_state_next = ST_FILL;
            default:                       w_state_next = ST_FILL;
        endcase
    end

    // Clearing on release means lanes past in_last are already zero when filling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_arr <= '0;
        end else if (w_release) begin
            r_state_arr <= '0;
        end else if (w_accept) begin
            r_state_arr[w_x][w_y] <= bus.in_lane;
        end
    end

    assign bus.in_ready    = (r_state == ST_FILL);
    assign bus.state_valid = (r_state == ST_FULL);
    assign bus.state_o     = r_state_arr;
    assign bus.lanes_o     = w_count;
endmodule

// File: tb/tb_string_to_state_loader.sv
// Scoreboard bench: lane stimulus feeds a bitstring-level model, a monitor
// compares each presented state block and its hold/release behaviour.
module tb_string_to_state_loader;
    import keccak_pkg::*;

    typedef struct {
        state_t     st;
        logic [4:0] n;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    string_to_state_loader_if bus_a ();
    string_to_state_loader_if bus_b ();

    string_to_state_loader #(.RATE_LANES(17)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    string_to_state_loader #(.RATE_LANES(25)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  q_a[$];
    exp_t  q_b[$];
    lane_t lanes_a[$];
    lane_t lanes_b[$];

    // 0 = hold low, 1 = tied high, 2 = random per cycle
    int sr_mode_a = 0;
    int sr_mode_b = 0;

    bit     prev_sv[2];
    bit     prev_hs[2];
    state_t held[2];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void chk_state(string nm, state_t act, state_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    if (act[x][y] !== exp[x][y]) begin
                        $display("FAIL %s: A[%0d][%0d] got %h expected %h", nm, x, y, act[x][y], exp[x][y]);
                        return;
                    end
                end
            end
        end
    endfunction

    // Bitstring view: lane i occupies bits [64i+63:64i]; then map bit 64(5y+x)+z to A[x][y][z].
    function automatic exp_t build(lane_t l[$]);
        exp_t          e;
        logic [1599:0] flat;
        flat = '0;
        foreach (l[i]) flat[64*i +: 64] = l[i];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                e.st[x][y] = flat[64*(5*y + x) +: 64];
        e.n = 5'(l.size());
        return e;
    endfunction

    function automatic bit model_accept(int id, lane_t lane, bit last);
        if (id == 0) begin
            lanes_a.push_back(lane);
            if (last || lanes_a.size() == 17) begin
                q_a.push_back(build(lanes_a));
                lanes_a.delete();
                return 1'b1;
            end
        end else begin
            lanes_b.push_back(lane);
            if (last || lanes_b.size() == 25) begin
                q_b.push_back(build(lanes_b));
                lanes_b.delete();
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void mon(int id, logic sv, logic sr, logic ir, state_t st, logic [4:0] lanes);
        exp_t  e;
        string tag;
        tag = (id == 0) ? "A" : "B";
        if (prev_hs[id]) begin
            chk({tag, " release state_o"}, 64'(st == '0), 64'd1);
            chk({tag, " release lanes_o"}, 64'(lanes), 64'd0);
            chk({tag, " release in_ready"}, 64'(ir), 64'd1);
            chk({tag, " release state_valid"}, 64'(sv), 64'd0);
        end
        if (sv && !prev_sv[id]) begin
            n_checks++;
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                n_fail++;
                $display("FAIL %s unexpected block: lanes_o=%0d, none expected", tag, lanes);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                chk_state({tag, " block state"}, st, e.st);
                chk({tag, " block lanes_o"}, 64'(lanes), 64'(e.n));
            end
            chk({tag, " full in_ready"}, 64'(ir), 64'd0);
            held[id] = st;
        end else if (sv) begin
            chk_state({tag, " hold state"}, st, held[id]);
            chk({tag, " hold in_ready"}, 64'(ir), 64'd0);
        end
        prev_sv[id] = sv;
        prev_hs[id] = sv && sr;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            prev_sv = '{0, 0};
            prev_hs = '{0, 0};
        end else begin
            mon(0, bus_a.state_valid, bus_a.state_ready, bus_a.in_ready, bus_a.state_o, bus_a.lanes_o);
            mon(1, bus_b.state_valid, bus_b.state_ready, bus_b.in_ready, bus_b.state_o, bus_b.lanes_o);
        end
    end

    always @(posedge clk) begin
        #2;
        bus_a.state_ready = (sr_mode_a == 2) ? 1'($urandom_range(0, 1)) : (sr_mode_a == 1);
        bus_b.state_ready = (sr_mode_b == 2) ? 1'($urandom_range(0, 1)) : (sr_mode_b == 1);
    end

    task automatic set_in(int id, logic v, lane_t lane, logic last);
        if (id == 0) begin
            bus_a.in_valid = v; bus_a.in_lane = lane; bus_a.in_last = last;
        end else begin
            bus_b.in_valid = v; bus_b.in_lane = lane; bus_b.in_last = last;
        end
    endtask

    function automatic logic get_rdy(int id);
        return (id == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    function automatic logic get_sv(int id);
        return (id == 0) ? bus_a.state_valid : bus_b.state_valid;
    endfunction

    // Offer one lane, wait for acceptance, update the model, check 1-cycle valid latency.
    task automatic send(int id, lane_t lane, bit last);
        int waited = 0;
        set_in(id, 1'b1, lane, last);
        while (!get_rdy(id)) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 300) begin
                n_checks++; n_fail++;
                $display("FAIL %0d send timeout: in_ready stuck at 0, required 1", id);
                set_in(id, 1'b0, '0, 1'b0);
                return;
            end
        end
        @(posedge clk); #1;
        set_in(id, 1'b0, {$urandom, $urandom}, 1'b0);
        $display("lane id=%0d data=%h last=%0d", id, lane, last);
        if (model_accept(id, lane, last)) begin
            @(negedge clk);
            chk("valid latency", 64'(get_sv(id)), 64'd1);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_ready_a();
        sr_mode_a = 1;
        @(posedge clk); #1;
        sr_mode_a = 0;
        idle(1);
    endtask

    initial begin
        int wait_cnt;
        set_in(0, 1'b0, '0, 1'b0);
        set_in(1, 1'b0, '0, 1'b0);
        bus_a.state_ready = 1'b0;
        bus_b.state_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("reset state_o", 64'(bus_a.state_o == '0), 64'd1);
        chk("reset lanes_o", 64'(bus_a.lanes_o), 64'd0);
        chk("reset state_valid", 64'(bus_a.state_valid), 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("reset in_ready", 64'(bus_a.in_ready), 64'd1);

        // Single lane with in_last, then backpressure with junk on the lane input
        send(0, 64'h1, 1'b1);
        chk("single A00", bus_a.state_o[0][0], 64'h1);
        chk("single lanes_o", 64'(bus_a.lanes_o), 64'd1);
        set_in(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        idle(10);
        set_in(0, 1'b0, '0, 1'b0);
        pulse_ready_a();

        // Full 17-lane block, lanes carry i+1
        for (int i = 0; i < 17; i++) send(0, lane_t'(i + 1), 1'b0);
        chk("full A21", bus_a.state_o[2][1], 64'd8);
        chk("full A13", bus_a.state_o[1][3], 64'd17);
        chk("full A23", bus_a.state_o[2][3], 64'd0);
        chk("full A44", bus_a.state_o[4][4], 64'd0);
        idle(2);
        pulse_ready_a();

        // Asynchronous reset after 5 lanes
        for (int i = 0; i < 5; i++) send(0, {$urandom, $urandom}, 1'b0);
        #2 reset = 1'b0;
        lanes_a.delete();
        #1;
        chk("midreset state_o", 64'(bus_a.state_o == '0), 64'd1);
        chk("midreset lanes_o", 64'(bus_a.lanes_o), 64'd0);
        chk("midreset state_valid", 64'(bus_a.state_valid), 64'd0);
        #13 reset = 1'b1;
        @(posedge clk); #1;
        chk("postreset in_ready", 64'(bus_a.in_ready), 64'd1);
        send(0, 64'hC0FF_EE00_1234_5678, 1'b1);
        chk("postreset A00", bus_a.state_o[0][0], 64'hC0FF_EE00_1234_5678);
        pulse_ready_a();

        // Back-to-back blocks with state_ready tied high
        sr_mode_a = 1;
        idle(1);
        for (int i = 0; i < 17; i++) send(0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        for (int i = 0; i < 3; i++) send(0, 64'h5, i == 2);

        // Random block lengths, gaps and consumer backpressure
        sr_mode_a = 2;
        for (int b = 0; b < 8; b++) begin
            int len = $urandom_range(1, 17);
            for (int i = 0; i < len; i++) begin
                send(0, {$urandom, $urandom}, i == len - 1);
                idle($urandom_range(0, 2));
            end
        end

        // 25-lane configuration, lanes carry i
        for (int i = 0; i < 25; i++) send(1, lane_t'(i), 1'b0);
        chk("r25 A44", bus_b.state_o[4][4], 64'd24);
        chk("r25 A01", bus_b.state_o[0][1], 64'd5);
        chk("r25 lanes_o", 64'(bus_b.lanes_o), 64'd25);

        // Drain every outstanding expected block
        sr_mode_a = 1;
        sr_mode_b = 1;
        wait_cnt = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && wait_cnt < 200) begin
            idle(1);
            wait_cnt++;
        end
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d blocks never presented, required 0", q_a.size(), q_b.size());
        end
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
